// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t       : controller FSM state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH : default operand width in bits
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder. It is the only arithmetic cell in the
// serial adder, and the controller reuses it for every bit position.
//   a, b, cin : addend bits and carry-in
//   s, co     : sum bit and carry-out
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. It accepts one operand set through a
// valid/ready handshake and adds it LSB first through a single shared full
// adder cell, one bit per cycle. The result is then held until the consumer
// accepts it.
//   clk, rst_n          : clock and synchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy                : operation in progress (RUN or DONE)
//
// state | meaning
// IDLE  | waiting for an operand set; last result still on sum/cout
// RUN   | adding bit cnt each cycle, WIDTH cycles in total
// DONE  | result valid, held until out_ready
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] bit_mask;
  logic             fa_a;
  logic             fa_b;
  logic             fa_s;
  logic             fa_co;

  // Select operand bits with a shift rather than a direct cnt index. cnt is
  // one bit wider than a bit position needs, and the shift avoids a
  // mismatched index width.
  always_comb begin
    a_sh     = a_r >> cnt;
    b_sh     = b_r >> cnt;
    fa_a     = a_sh[0];
    fa_b     = b_sh[0];
    bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << cnt;
  end

  fa_bit u_fa (
    .a   (fa_a),
    .b   (fa_b),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            carry    <= cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // Only bit cnt of sum changes. The remaining bits keep the previous
          // result until this run overwrites them.
          sum   <= fa_s ? (sum | bit_mask) : (sum & ~bit_mask);
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout      <= fa_co;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic prev_ov = 1'b0;
  logic [W:0] exp_q[$];
  int         acc_q[$];
  int         last_acc;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: latency on each out_valid rise; result compared on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk("latency_no_accept", 1, 0);
        else chk("latency_edges", 64'(cyc - acc_q.pop_front() + 1), W + 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", {sum, cout}, 0);
        else chk("result_cout_sum", {cout, sum}, exp_q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one operand set for one accepting edge, and
  // queues the expected result.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic tc, input logic [W:0] expv);
    int n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    exp_q.push_back(expv);
    step();
    acc_q.push_back(cyc);
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic rc;
    int prev_acc;

    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    step();

    // 0+0, then overflow cases
    send(8'h00, 8'h00, 1'b0, 9'h000);
    drain();
    send(8'hFF, 8'h01, 1'b0, 9'h100);
    drain();
    send(8'hA5, 8'h5A, 1'b1, 9'h100);
    drain();
    chk("idle_retains_sum", sum, 8'h00);
    chk("idle_retains_cout", cout, 1);

    // result held while the consumer stalls
    out_ready = 1'b0;
    send(8'h3C, 8'h0F, 1'b0, 9'h04B);
    wait_ov();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_sum", sum, 8'h4B);
      chk("stall_cout", cout, 0);
      chk("stall_in_ready", in_ready, 0);
    end
    step();
    out_ready = 1'b1;
    step();
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_busy", busy, 0);

    // in_valid during RUN is ignored
    send(8'h01, 8'h01, 1'b0, 9'h002);
    step(); step();
    a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drain();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_second_capture", busy, 0);
    end

    // reset during RUN aborts the operation
    send(8'h55, 8'h66, 1'b1, 9'h0BC);
    step(); step(); step();
    rst_n = 1'b0;
    step();
    exp_q.delete();
    acc_q.delete();
    rst_n = 1'b1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) chk("abort_no_out_valid", out_valid, 0);
    end
    chk("abort_still_idle", busy, 0);

    // random back-to-back stream
    prev_acc = -1;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
      if (prev_acc >= 0 && (last_acc - prev_acc) != W + 2)
        chk("stream_spacing", 64'(last_acc - prev_acc), W + 2);
      prev_acc = last_acc;
    end
    drain();
    chk("stream_last_spacing_seen", 64'(prev_acc > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
